// File: rtl/prog_fetch_if.sv
// prog_fetch_if
//   Bundles the decode-side controls and the fetch-side results of the
//   program-counter / fetch controller.
//   master : the decode/driver side. It drives program select, stall and the
//            decode controls, and observes pc/fetch_valid/done/instr_cnt.
//   slave  : the fetch controller itself.
//   Signals:
//     pMux        program select (chooses one of four entry points)
//     stall       hold PC and state this cycle
//     halt        current instruction is HALT
//     jump_en     absolute jump, target in jump_tgt
//     br_taken    relative branch taken, signed offset in br_off
//     pc          instruction ROM address
//     fetch_valid pc addresses a live instruction
//     done        program finished (sticky until program select changes)
//     instr_cnt   instructions retired since program start (saturating)
interface prog_fetch_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
);
    logic [1:0]              pMux;
    logic                    stall;
    logic                    halt;
    logic                    jump_en;
    logic [PC_W-1:0]         jump_tgt;
    logic                    br_taken;
    logic signed [OFF_W-1:0] br_off;

    logic [PC_W-1:0]         pc;
    logic                    fetch_valid;
    logic                    done;
    logic [CNT_W-1:0]        instr_cnt;

    modport master (
        output pMux, stall, halt, jump_en, jump_tgt, br_taken, br_off,
        input  pc, fetch_valid, done, instr_cnt
    );

    modport slave (
        input  pMux, stall, halt, jump_en, jump_tgt, br_taken, br_off,
        output pc, fetch_valid, done, instr_cnt
    );
endinterface

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl
//   Program-counter / fetch controller for the single-cycle core. On leaving
//   IDLE it loads one of four entry points selected by pMux, then steps the PC
//   into the instruction ROM, applying absolute jumps and signed relative
//   branches from decode. A HALT instruction moves it to DONE, where done is
//   held until the program select changes, which restarts through IDLE.
//   Ports:
//     clk    rising-edge core clock
//     reset  asynchronous, active-high; returns every register to its idle value
//     bus    prog_fetch_if.slave (decode controls in; pc, fetch_valid, done,
//            instr_cnt out -- all outputs are registered)
module prog_fetch_ctrl #(
    parameter int PC_W   = 10,
    parameter int OFF_W  = 8,
    parameter int START0 = 0,
    parameter int START1 = 128,
    parameter int START2 = 256,
    parameter int START3 = 384,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         reset,
    prog_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [1:0]       pmux_q, pmux_d;

    // Entry point for a given program select.
    function automatic logic [PC_W-1:0] start_pc(input logic [1:0] sel);
        logic [PC_W-1:0] r;
        case (sel)
            2'b00:   r = PC_W'(START0);
            2'b01:   r = PC_W'(START1);
            2'b10:   r = PC_W'(START2);
            default: r = PC_W'(START3);
        endcase
        return r;
    endfunction

    // Relative branch: the offset is sign-extended to PC width, and the sum is
    // truncated to PC_W bits so both forward and backward overflow wrap.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0]         base,
        input logic signed [OFF_W-1:0] off
    );
        logic signed [PC_W-1:0] off_ext;
        off_ext = PC_W'(off);
        return base + off_ext;
    endfunction

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
            instr_cnt_q   <= '0;
            pmux_q        <= 2'b00;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            done_q        <= done_d;
            instr_cnt_q   <= instr_cnt_d;
            pmux_q        <= pmux_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.stall && bus.halt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new program select leaves DONE; the same one parks here.
                if (bus.pMux != pmux_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next register values for the PC, flags and counter
    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        done_d        = done_q;
        instr_cnt_d   = instr_cnt_q;
        pmux_d        = pmux_q;
        case (state_q)
            ST_IDLE: begin
                // Stall is deliberately not consulted: IDLE lasts one cycle.
                pc_d          = start_pc(bus.pMux);
                pmux_d        = bus.pMux;
                fetch_valid_d = 1'b1;
                done_d        = 1'b0;
                instr_cnt_d   = '0;
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    instr_cnt_d = sat_inc(instr_cnt_q);
                    if (bus.halt) begin
                        // PC stays on the HALT instruction.
                        done_d        = 1'b1;
                        fetch_valid_d = 1'b0;
                    end else if (bus.jump_en) begin
                        pc_d = bus.jump_tgt;
                    end else if (bus.br_taken) begin
                        pc_d = branch_target(pc_q, bus.br_off);
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                fetch_valid_d = 1'b0;
                if (bus.pMux != pmux_q) begin
                    done_d = 1'b0;
                end
            end
            default: begin
                fetch_valid_d = 1'b0;
                done_d        = 1'b0;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.done        = done_q;
    assign bus.instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
module tb_prog_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;

    typedef struct {
        logic             stall;
        logic             halt;
        logic             jump_en;
        logic [PC_W-1:0]  jump_tgt;
        logic             br_taken;
        logic [OFF_W-1:0] br_off;
        logic [1:0]       pmux;
        logic [PC_W-1:0]  e_pc;
        logic             e_fv;
        logic             e_done;
        logic [15:0]      e_cnt;
    } vec_t;

    localparam int NV = 22;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [1:0]              pmux_r = 2'b01;
    logic                    stall_r = 1'b0;
    logic                    halt_r = 1'b0;
    logic                    jump_r = 1'b0;
    logic [PC_W-1:0]         tgt_r = '0;
    logic                    br_r = 1'b0;
    logic signed [OFF_W-1:0] off_r = '0;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NV];

    prog_fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(16)) bus ();
    prog_fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(4))  bus4 ();

    assign bus.pMux      = pmux_r;
    assign bus.stall     = stall_r;
    assign bus.halt      = halt_r;
    assign bus.jump_en   = jump_r;
    assign bus.jump_tgt  = tgt_r;
    assign bus.br_taken  = br_r;
    assign bus.br_off    = off_r;
    assign bus4.pMux     = pmux_r;
    assign bus4.stall    = stall_r;
    assign bus4.halt     = halt_r;
    assign bus4.jump_en  = jump_r;
    assign bus4.jump_tgt = tgt_r;
    assign bus4.br_taken = br_r;
    assign bus4.br_off   = off_r;

    prog_fetch_ctrl #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    prog_fetch_ctrl #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int s, int h, int j, int tgt, int b, int off, int pm,
                                int epc, int efv, int edn, int ecnt);
        vec_t v;
        v.stall    = (s != 0);
        v.halt     = (h != 0);
        v.jump_en  = (j != 0);
        v.jump_tgt = PC_W'(tgt);
        v.br_taken = (b != 0);
        v.br_off   = OFF_W'(off);
        v.pmux     = 2'(pm);
        v.e_pc     = PC_W'(epc);
        v.e_fv     = (efv != 0);
        v.e_done   = (edn != 0);
        v.e_cnt    = 16'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int epc, input int efv,
                            input int edn, input int ecnt);
        chk($sformatf("%s_pc", name),   32'(bus.pc),          32'(epc));
        chk($sformatf("%s_fv", name),   32'(bus.fetch_valid), 32'(efv));
        chk($sformatf("%s_done", name), 32'(bus.done),        32'(edn));
        chk($sformatf("%s_cnt", name),  32'(bus.instr_cnt),   32'(ecnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_r = 1'b0;
        halt_r  = 1'b0;
        jump_r  = 1'b0;
        tgt_r   = '0;
        br_r    = 1'b0;
        off_r   = '0;
    endtask

    initial begin
        // Start at pMux=01, count up, relative branches and jump-over-branch.
        vecs[0]  = mk(0, 0, 0,    0, 0, 'h00, 1,  128, 1, 0,  0);
        vecs[1]  = mk(0, 0, 0,    0, 0, 'h00, 1,  129, 1, 0,  1);
        vecs[2]  = mk(0, 0, 0,    0, 0, 'h00, 1,  130, 1, 0,  2);
        vecs[3]  = mk(0, 0, 1,  140, 0, 'h00, 1,  140, 1, 0,  3);
        vecs[4]  = mk(0, 0, 0,    0, 1, 'hF6, 1,  130, 1, 0,  4);
        vecs[5]  = mk(0, 0, 0,    0, 1, 'h05, 1,  135, 1, 0,  5);
        vecs[6]  = mk(0, 0, 1,   64, 1, 'h05, 1,   64, 1, 0,  6);
        // PC wrap forward by increment and by branch, backward by branch.
        vecs[7]  = mk(0, 0, 1, 1022, 0, 'h00, 1, 1022, 1, 0,  7);
        vecs[8]  = mk(0, 0, 0,    0, 0, 'h00, 1, 1023, 1, 0,  8);
        vecs[9]  = mk(0, 0, 0,    0, 0, 'h00, 1,    0, 1, 0,  9);
        vecs[10] = mk(0, 0, 1,    2, 0, 'h00, 1,    2, 1, 0, 10);
        vecs[11] = mk(0, 0, 0,    0, 1, 'hFB, 1, 1021, 1, 0, 11);
        vecs[12] = mk(0, 0, 0,    0, 1, 'h05, 1,    2, 1, 0, 12);
        // Stall holds off a pending halt, then halt lands.
        vecs[13] = mk(1, 1, 0,    0, 0, 'h00, 1,    2, 1, 0, 12);
        vecs[14] = mk(1, 1, 0,    0, 0, 'h00, 1,    2, 1, 0, 12);
        vecs[15] = mk(1, 1, 0,    0, 0, 'h00, 1,    2, 1, 0, 12);
        vecs[16] = mk(0, 1, 0,    0, 0, 'h00, 1,    2, 0, 1, 13);
        // DONE ignores decode; program change passes through IDLE.
        vecs[17] = mk(0, 0, 1,  500, 1, 'h05, 1,    2, 0, 1, 13);
        vecs[18] = mk(1, 1, 0,    0, 0, 'h00, 1,    2, 0, 1, 13);
        vecs[19] = mk(0, 0, 0,    0, 0, 'h00, 2,    2, 0, 0, 13);
        vecs[20] = mk(0, 0, 0,    0, 0, 'h00, 2,  256, 1, 0,  0);
        // Halt beats a simultaneous jump.
        vecs[21] = mk(0, 1, 1,  100, 0, 'h00, 2,  256, 0, 1,  1);

        idle_inputs();
        pmux_r = 2'b01;
        #1 reset = 1'b1;
        #2;
        chk_outs("reset", 0, 0, 0, 0);
        #17 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall_r = vecs[i].stall;
            halt_r  = vecs[i].halt;
            jump_r  = vecs[i].jump_en;
            tgt_r   = vecs[i].jump_tgt;
            br_r    = vecs[i].br_taken;
            off_r   = vecs[i].br_off;
            pmux_r  = vecs[i].pmux;
            step();
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].e_pc), int'(vecs[i].e_fv),
                     int'(vecs[i].e_done), int'(vecs[i].e_cnt));
        end

        // Same program select for 100 cycles in DONE, decode inputs toggling.
        for (int i = 0; i < 100; i++) begin
            stall_r = 1'($urandom);
            halt_r  = 1'($urandom);
            jump_r  = 1'($urandom);
            tgt_r   = PC_W'($urandom);
            br_r    = 1'($urandom);
            off_r   = OFF_W'($urandom);
            step();
            chk($sformatf("hold%0d_done", i), 32'(bus.done), 32'd1);
        end
        chk_outs("hold_end", 256, 0, 1, 1);

        // Switch to pMux=11 while stalled: stall does not delay the reload.
        idle_inputs();
        stall_r = 1'b1;
        pmux_r  = 2'b11;
        step();
        chk_outs("sw_idle", 256, 0, 0, 1);
        step();
        chk_outs("sw_load", 384, 1, 0, 0);
        stall_r = 1'b0;
        step();
        chk_outs("sw_run", 385, 1, 0, 1);

        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0);
        chk("async_rst_cnt4", 32'(bus4.instr_cnt), 32'd0);
        step();
        chk_outs("rst_held", 0, 0, 0, 0);

        // Saturation of a 4-bit counter over 20 instructions.
        pmux_r = 2'b00;
        reset  = 1'b0;
        step();
        chk_outs("sat_load", 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat%0d_cnt16", k), 32'(bus.instr_cnt), 32'(k));
            chk($sformatf("sat%0d_cnt4", k), 32'(bus4.instr_cnt), 32'((k > 15) ? 15 : k));
        end
        chk("sat_pc", 32'(bus4.pc), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
